// File: rtl/wb_pkg.sv
// Shared writeback/MEM definitions: stage state encoding, source-select and load-size codes.
package wb_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

  // Code 11 is reserved and decodes the same as ALU.
  typedef enum logic [1:0] {
    MTR_ALU     = 2'd0,
    MTR_LOAD    = 2'd1,
    MTR_PC4     = 2'd2,
    MTR_ALU_ALT = 2'd3
  } memtoreg_e;

  // Code 11 is reserved and decodes the same as word.
  typedef enum logic [1:0] {
    LD_WORD     = 2'd0,
    LD_HALF     = 2'd1,
    LD_BYTE     = 2'd2,
    LD_WORD_ALT = 2'd3
  } ldsize_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment and sign/zero extension of a data-memory read word.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    byteVal = shifted[7:0];
    halfVal = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o  = rdata_i;
    case (size_i)
      LD_BYTE: data_o = {{24{signed_i & byteVal[7]}}, byteVal};
      LD_HALF: data_o = {{16{signed_i & halfVal[15]}}, halfVal};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, waits for load data when needed, then commits it to the register file.
module wb_stage
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_regwr,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_memtoreg,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc4,
  input  logic        in_memrd,
  input  logic [1:0]  in_ldsize,
  input  logic        in_ldsigned,
  input  logic [1:0]  in_byteoff,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        flush,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic [31:0] retired
);

  wb_state_e   state_q, state_d;
  logic [4:0]  pendRd_q, pendRd_d;
  logic        pendRegwr_q, pendRegwr_d;
  logic [1:0]  pendSize_q, pendSize_d;
  logic        pendSigned_q, pendSigned_d;
  logic [1:0]  pendOff_q, pendOff_d;
  logic [4:0]  rfAddr_q, rfAddr_d;
  logic [31:0] rfWdata_q, rfWdata_d;
  logic        commitWr_q, commitWr_d;
  logic [31:0] retired_q, retired_d;

  logic        accept;
  logic [31:0] aluSel;
  logic [31:0] loadData;

  load_align u_load_align (
    .rdata_i  (mem_rdata),
    .size_i   (pendSize_q),
    .signed_i (pendSigned_q),
    .off_i    (pendOff_q),
    .data_o   (loadData)
  );

  assign in_ready = ~reset & ~flush & (state_q != WAIT_MEM);
  assign accept   = in_valid & in_ready;
  assign aluSel   = (in_memtoreg == MTR_PC4) ? in_pc4 : in_alu;

  // rf_addr/rf_wdata only change when an entry enters COMMIT, so they stay stable otherwise.
  always_comb begin
    state_d      = state_q;
    pendRd_d     = pendRd_q;
    pendRegwr_d  = pendRegwr_q;
    pendSize_d   = pendSize_q;
    pendSigned_d = pendSigned_q;
    pendOff_d    = pendOff_q;
    rfAddr_d     = rfAddr_q;
    rfWdata_d    = rfWdata_q;
    commitWr_d   = commitWr_q;
    retired_d    = retired_q + {31'd0, state_q == COMMIT};
    case (state_q)
      EMPTY, COMMIT: begin
        state_d = EMPTY;
        if (accept) begin
          if (in_memrd) begin
            pendRd_d     = in_rd;
            pendRegwr_d  = in_regwr;
            pendSize_d   = in_ldsize;
            pendSigned_d = in_ldsigned;
            pendOff_d    = in_byteoff;
            state_d      = WAIT_MEM;
          end else begin
            rfAddr_d   = in_rd;
            rfWdata_d  = aluSel;
            commitWr_d = in_regwr & (in_rd != 5'd0);
            state_d    = COMMIT;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d = EMPTY;
        end else if (mem_rvalid) begin
          rfAddr_d   = pendRd_q;
          rfWdata_d  = loadData;
          commitWr_d = pendRegwr_q & (pendRd_q != 5'd0);
          state_d    = COMMIT;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      pendRd_q     <= '0;
      pendRegwr_q  <= 1'b0;
      pendSize_q   <= '0;
      pendSigned_q <= 1'b0;
      pendOff_q    <= '0;
      rfAddr_q     <= '0;
      rfWdata_q    <= '0;
      commitWr_q   <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pendRd_q     <= pendRd_d;
      pendRegwr_q  <= pendRegwr_d;
      pendSize_q   <= pendSize_d;
      pendSigned_q <= pendSigned_d;
      pendOff_q    <= pendOff_d;
      rfAddr_q     <= rfAddr_d;
      rfWdata_q    <= rfWdata_d;
      commitWr_q   <= commitWr_d;
      retired_q    <= retired_d;
    end
  end

  assign rf_wr    = (state_q == COMMIT) & commitWr_q;
  assign rf_addr  = rfAddr_q;
  assign rf_wdata = rfWdata_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: register-file writes are predicted into a scoreboard and matched as they appear.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_regwr;
  logic [4:0]  in_rd;
  logic [1:0]  in_memtoreg;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic        in_memrd;
  logic [1:0]  in_ldsize;
  logic        in_ldsigned;
  logic [1:0]  in_byteoff;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        flush;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] retired;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wbExp_t;

  wbExp_t sb[$];
  int cycle      = 0;
  int checkCount = 0;
  int passCount  = 0;

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regwr    (in_regwr),
    .in_rd       (in_rd),
    .in_memtoreg (in_memtoreg),
    .in_alu      (in_alu),
    .in_pc4      (in_pc4),
    .in_memrd    (in_memrd),
    .in_ldsize   (in_ldsize),
    .in_ldsigned (in_ldsigned),
    .in_byteoff  (in_byteoff),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .flush       (flush),
    .rf_wr       (rf_wr),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock and match any register-file write against the scoreboard.
  task automatic tick();
    wbExp_t e;
    @(posedge clk);
    cycle++;
    @(negedge clk);
    if (rf_wr !== 1'b0) begin
      if (sb.size() == 0) begin
        check32("spuriousWr", {31'd0, rf_wr}, 32'd0);
      end else begin
        e = sb.pop_front();
        check32("wrCycle", cycle, e.cyc);
        check32("wrAddr", {27'd0, rf_addr}, {27'd0, e.rd});
        check32("wrData", rf_wdata, e.data);
      end
    end
  endtask

  task automatic expectWr(input logic [4:0] rd, input logic [31:0] data);
    wbExp_t e;
    e.rd   = rd;
    e.data = data;
    e.cyc  = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic valid, input logic memrd, input logic regwr,
                               input logic [4:0] rd, input logic [1:0] mtr,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [1:0] size, input logic sgn, input logic [1:0] off);
    in_valid    = valid;
    in_memrd    = memrd;
    in_regwr    = regwr;
    in_rd       = rd;
    in_memtoreg = mtr;
    in_alu      = alu;
    in_pc4      = pc4;
    in_ldsize   = size;
    in_ldsigned = sgn;
    in_byteoff  = off;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expRetired);
    check32({tag, "_pending"}, 32'(sb.size()), 32'd0);
    check32({tag, "_retired"}, retired, expRetired);
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 2'b00, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 2'b00);
    mem_rvalid = 1'b1;
    flush      = 1'b1;
    @(negedge clk);

    // Reset held two cycles with other controls active.
    tick();
    tick();
    check32("rstRfWr", {31'd0, rf_wr}, 32'd0);
    check32("rstRfAddr", {27'd0, rf_addr}, 32'd0);
    check32("rstRfWdata", rf_wdata, 32'd0);
    check32("rstRetired", retired, 32'd0);
    check32("rstInReady", {31'd0, in_ready}, 32'd0);
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    in_valid   = 1'b0;
    reset      = 1'b0;
    #1;
    check32("postRstReady", {31'd0, in_ready}, 32'd1);

    // Back-to-back ALU writes.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 2'b00, 1'b0, 2'b00);
    expectWr(5'd5, 32'h1234_5678);
    tick();
    check32("commitReady", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 2'b00, 32'h0000_000A, 32'h0, 2'b00, 1'b0, 2'b00);
    expectWr(5'd6, 32'h0000_000A);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("alu", 32'd2);

    // Signed byte load, three wait cycles, stale rvalid in accept cycle is ignored.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 2'b01, 32'h0, 32'h0, 2'b10, 1'b1, 2'b11);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check32("waitReady", {31'd0, in_ready}, 32'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_0000;
    expectWr(5'd7, 32'hFFFF_FF80);
    tick();
    mem_rvalid = 1'b0;
    tick();
    checkOutput("ldByte", 32'd3);

    // Unsigned half load from upper half.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd8, 2'b01, 32'h0, 32'h0, 2'b01, 1'b0, 2'b10);
    tick();
    in_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF_1234;
    expectWr(5'd8, 32'h0000_BEEF);
    tick();
    mem_rvalid = 1'b0;
    tick();
    checkOutput("ldHalf", 32'd4);

    // Flush with rvalid in WAIT_MEM; a waiting ALU op must not be accepted.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 2'b01, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd10, 2'b00, 32'h0000_0077, 32'h0, 2'b00, 1'b0, 2'b00);
    flush      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    #1;
    check32("flushReady", {31'd0, in_ready}, 32'd0);
    tick();
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    in_valid   = 1'b0;
    #1;
    check32("flushEmpty", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("flush", 32'd4);

    // Flush while COMMIT keeps the commit but blocks acceptance.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd11, 2'b00, 32'h0000_0055, 32'h0, 2'b00, 1'b0, 2'b00);
    expectWr(5'd11, 32'h0000_0055);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 2'b00, 32'h0000_0066, 32'h0, 2'b00, 1'b0, 2'b00);
    #1;
    check32("commitFlushReady", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    checkOutput("commitFlush", 32'd5);

    // jal to rd=0 retires without a write; jal to rd=12 and code 11 selecting ALU.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 2'b10, 32'h0000_0999, 32'h0000_0100, 2'b00, 1'b0, 2'b00);
    tick();
    check32("rd0Wr", {31'd0, rf_wr}, 32'd0);
    check32("rd0Wdata", rf_wdata, 32'h0000_0100);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd12, 2'b10, 32'h0000_0999, 32'h0000_0204, 2'b00, 1'b0, 2'b00);
    expectWr(5'd12, 32'h0000_0204);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd13, 2'b11, 32'h0000_0033, 32'h0000_0044, 2'b00, 1'b0, 2'b00);
    expectWr(5'd13, 32'h0000_0033);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd14, 2'b00, 32'h0000_00AB, 32'h0, 2'b00, 1'b0, 2'b00);
    tick();
    check32("noRegwr", {31'd0, rf_wr}, 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("jal", 32'd9);

    // Retired counter wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    check32("preWrap", retired, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 2'b00, 32'h0000_0E0E, 32'h0, 2'b00, 1'b0, 2'b00);
    expectWr(5'd14, 32'h0000_0E0E);
    tick();
    in_valid = 1'b0;
    tick();
    checkOutput("wrap", 32'd0);

    // Reset during WAIT_MEM drops the load.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd15, 2'b01, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00);
    tick();
    in_valid   = 1'b0;
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    tick();
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    check32("midRstAddr", {27'd0, rf_addr}, 32'd0);
    check32("midRstWdata", rf_wdata, 32'd0);
    checkOutput("midRst", 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
